// File: rtl/tc0_host.sv
// Host-side initiator for timer0: command stream to register strobes,
// global I bit ownership and vectored interrupt acknowledge.
module tc0_host #(
  parameter int IRQ_LATENCY = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  input  logic       sei,
  input  logic       cli,
  input  logic       reti,
  output logic       write,
  output logic       read,
  output logic [7:0] addr,
  output logic [7:0] wdata,
  input  logic [7:0] rdata,
  input  logic       interrupt_request,
  output logic       status_reg_interrupt_enable,
  output logic       interrupt_executed,
  output logic       in_isr,
  output logic [7:0] irq_count
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] WR     = 3'd1;
  localparam logic [2:0] RD     = 3'd2;
  localparam logic [2:0] RDCAP  = 3'd3;
  localparam logic [2:0] VECTOR = 3'd4;
  localparam logic [2:0] ACK    = 3'd5;

  localparam logic [3:0] VLOAD = 4'(IRQ_LATENCY - 1);

  logic [2:0] state;
  logic [3:0] vcnt;
  logic       i_bit;
  logic       take;

  assign take = interrupt_request & i_bit & ~in_isr;

  // Interrupt entry wins over a command offered in the same IDLE cycle
  assign cmd_ready = ~rst & (state == IDLE) & ~take;

  assign write = (state == WR);
  assign read  = (state == RD);
  assign interrupt_executed = (state == ACK);
  assign status_reg_interrupt_enable = i_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      vcnt      <= 4'd0;
      i_bit     <= 1'b0;
      in_isr    <= 1'b0;
      irq_count <= 8'd0;
      addr      <= 8'd0;
      wdata     <= 8'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'd0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (take) begin
            state <= VECTOR;
            vcnt  <= VLOAD;
          end else if (cmd_valid) begin
            addr  <= cmd_addr;
            wdata <= cmd_wdata;
            state <= cmd_write ? WR : RD;
          end
        end
        WR: state <= IDLE;
        RD: state <= RDCAP;
        RDCAP: begin
          rsp_rdata <= rdata;
          rsp_valid <= 1'b1;
          state     <= IDLE;
        end
        VECTOR: begin
          if (vcnt == 4'd0) state <= ACK;
          else vcnt <= vcnt - 4'd1;
        end
        ACK: begin
          irq_count <= irq_count + 8'd1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (state == IDLE && take) i_bit <= 1'b0;
      else if (cli) i_bit <= 1'b0;
      else if (sei || reti) i_bit <= 1'b1;

      // ACK beats a same-cycle reti so the new ISR is never lost
      if (state == ACK) in_isr <= 1'b1;
      else if (reti) in_isr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tc0_host.sv
// Bench for tc0_host: command table, interrupt sequences and
// randomized command/I-bit traffic against a transaction-level model.
module tb_tc0_host;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       sei;
  logic       cli;
  logic       reti;
  logic       write;
  logic       read;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       interrupt_request;
  logic       status_reg_interrupt_enable;
  logic       interrupt_executed;
  logic       in_isr;
  logic [7:0] irq_count;

  always #5 clk = ~clk;

  tc0_host #(.IRQ_LATENCY(4)) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .sei(sei),
    .cli(cli),
    .reti(reti),
    .write(write),
    .read(read),
    .addr(addr),
    .wdata(wdata),
    .rdata(rdata),
    .interrupt_request(interrupt_request),
    .status_reg_interrupt_enable(status_reg_interrupt_enable),
    .interrupt_executed(interrupt_executed),
    .in_isr(in_isr),
    .irq_count(irq_count)
  );

  // Timer register file stand-in: read data appears the cycle after read
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      rdata <= 8'h00;
    end else begin
      if (write) mem[addr] <= wdata;
      rdata <= read ? mem[addr] : 8'h00;
    end
  end

  int errors = 0;
  int checks = 0;
  logic [7:0] ref_mem [256];

  task automatic chk1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk8(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic chki(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr = 8'h00;
    cmd_wdata = 8'h00;
    sei = 1'b0;
    cli = 1'b0;
    reti = 1'b0;
    interrupt_request = 1'b0;
    repeat (n) step();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
  endtask

  task automatic pulse_sei();
    sei = 1'b1;
    step();
    sei = 1'b0;
  endtask

  task automatic pulse_reti();
    reti = 1'b1;
    step();
    reti = 1'b0;
  endtask

  // Returns cycles stepped until interrupt_executed, or -1 on timeout
  task automatic wait_ack(output int n);
    n = 0;
    while (!interrupt_executed && n < 30) begin
      step();
      n++;
    end
    if (!interrupt_executed) n = -1;
  endtask

  task automatic do_cmd(logic wr, logic [7:0] a, logic [7:0] d,
                        logic [7:0] exp);
    int n;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr = a;
    cmd_wdata = d;
    n = 0;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    if (!cmd_ready) begin
      chki("cmd_accept_timeout", n, 0);
      cmd_valid = 1'b0;
      return;
    end
    step();
    cmd_valid = 1'b0;
    if (wr) begin
      ref_mem[a] = d;
      chk1("wr_strobe", write, 1'b1);
      chk1("wr_no_read", read, 1'b0);
      chk8("wr_addr", addr, a);
      chk8("wr_data", wdata, d);
      chk1("wr_ready_low", cmd_ready, 1'b0);
      step();
      chk1("wr_strobe_end", write, 1'b0);
    end else begin
      chk1("rd_strobe", read, 1'b1);
      chk8("rd_addr", addr, a);
      step();
      chk1("rd_strobe_end", read, 1'b0);
      chk1("rsp_early", rsp_valid, 1'b0);
      step();
      chk1("rsp_valid", rsp_valid, 1'b1);
      chk8("rsp_rdata", rsp_rdata, exp);
      step();
      chk1("rsp_pulse_end", rsp_valid, 1'b0);
    end
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [9];
    int n;
    logic [8:0] rdy_pat;
    int rd_cnt;
    int acks;

    tbl[0] = '{1'b1, 8'h44, 8'h05, 8'h00};
    tbl[1] = '{1'b1, 8'h46, 8'hA7, 8'h00};
    tbl[2] = '{1'b0, 8'h46, 8'h00, 8'hA7};
    tbl[3] = '{1'b0, 8'h44, 8'h00, 8'h05};
    tbl[4] = '{1'b1, 8'h10, 8'h3C, 8'h00};
    tbl[5] = '{1'b0, 8'h10, 8'h00, 8'h3C};
    tbl[6] = '{1'b0, 8'h99, 8'h00, 8'h00};
    tbl[7] = '{1'b1, 8'hFF, 8'hFF, 8'h00};
    tbl[8] = '{1'b0, 8'hFF, 8'h00, 8'hFF};

    do_reset(2);
    chk1("rst_ready", cmd_ready, 1'b0);
    chk1("rst_write", write, 1'b0);
    chk1("rst_read", read, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk8("rst_rsp_rdata", rsp_rdata, 8'h00);
    chk8("rst_addr", addr, 8'h00);
    chk8("rst_wdata", wdata, 8'h00);
    chk1("rst_ibit", status_reg_interrupt_enable, 1'b0);
    chk1("rst_ack", interrupt_executed, 1'b0);
    chk1("rst_in_isr", in_isr, 1'b0);
    chk8("rst_irq_count", irq_count, 8'h00);
    rst = 1'b0;
    #1;
    chk1("idle_ready", cmd_ready, 1'b1);

    for (int i = 0; i < 9; i++) do_cmd(tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].exp);

    // Back-to-back reads: one accepted every 3 cycles
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr = 8'h46;
    rdy_pat = '0;
    rd_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      rdy_pat[i] = cmd_ready;
      if (read) rd_cnt++;
      step();
    end
    cmd_valid = 1'b0;
    chki("b2b_rd_ready_pattern", int'(rdy_pat), int'(9'b001001001));
    chki("b2b_rd_count", rd_cnt, 3);
    repeat (3) step();

    // Back-to-back writes: one every 2 cycles
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr = 8'h46;
    cmd_wdata = 8'hA7;
    rdy_pat = '0;
    for (int i = 0; i < 6; i++) begin
      rdy_pat[i] = cmd_ready;
      step();
    end
    cmd_valid = 1'b0;
    chki("b2b_wr_ready_pattern", int'(rdy_pat), int'(9'b000010101));
    repeat (2) step();

    // Interrupt taken in preference to a same-cycle command
    pulse_sei();
    chk1("sei_sets_i", status_reg_interrupt_enable, 1'b1);
    interrupt_request = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr = 8'h44;
    #1;
    chk1("irq_blocks_ready", cmd_ready, 1'b0);
    step();
    chk1("i_falls_on_entry", status_reg_interrupt_enable, 1'b0);
    chk1("no_early_ack", interrupt_executed, 1'b0);
    wait_ack(n);
    chki("ack_latency", n < 0 ? n : n + 1, 5);
    chk1("ack_ready_low", cmd_ready, 1'b0);
    step();
    chk1("ack_one_cycle", interrupt_executed, 1'b0);
    chk8("irq_count_1", irq_count, 8'd1);
    chk1("in_isr_set", in_isr, 1'b1);
    chk1("cmd_after_ack_ready", cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0;
    chk1("cmd_after_ack_read", read, 1'b1);
    step();
    step();
    chk1("cmd_after_ack_rsp", rsp_valid, 1'b1);
    chk8("cmd_after_ack_data", rsp_rdata, 8'h05);

    // Held request with sei: no nesting while in_isr
    pulse_sei();
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      if (interrupt_executed) acks++;
      step();
    end
    chki("no_nested_ack", acks, 0);
    pulse_reti();
    chk1("reti_clears_isr", in_isr, 1'b0);
    wait_ack(n);
    chki("retaken_after_reti", n < 0 ? 0 : 1, 1);
    step();
    chk8("irq_count_2", irq_count, 8'd2);
    interrupt_request = 1'b0;
    pulse_reti();

    // Masking
    cli = 1'b1;
    step();
    cli = 1'b0;
    chk1("cli_clears_i", status_reg_interrupt_enable, 1'b0);
    interrupt_request = 1'b1;
    acks = 0;
    for (int i = 0; i < 50; i++) begin
      if (interrupt_executed) acks++;
      step();
    end
    chki("masked_no_ack", acks, 0);
    interrupt_request = 1'b0;
    sei = 1'b1;
    cli = 1'b1;
    step();
    sei = 1'b0;
    cli = 1'b0;
    chk1("sei_cli_gives_0", status_reg_interrupt_enable, 1'b0);

    // reti together with cli
    pulse_sei();
    interrupt_request = 1'b1;
    wait_ack(n);
    interrupt_request = 1'b0;
    step();
    chk1("isr_before_reti_cli", in_isr, 1'b1);
    reti = 1'b1;
    cli = 1'b1;
    step();
    reti = 1'b0;
    cli = 1'b0;
    chk1("reti_cli_i", status_reg_interrupt_enable, 1'b0);
    chk1("reti_cli_isr", in_isr, 1'b0);

    // Reset during VECTOR
    pulse_sei();
    interrupt_request = 1'b1;
    step();
    step();
    do_reset(1);
    chk1("rst_vec_ack", interrupt_executed, 1'b0);
    chk8("rst_vec_count", irq_count, 8'h00);
    chk1("rst_vec_i", status_reg_interrupt_enable, 1'b0);
    rst = 1'b0;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      if (interrupt_executed) acks++;
      step();
    end
    chki("rst_vec_no_ack", acks, 0);
    chk8("rst_vec_count_after", irq_count, 8'h00);

    // 256 serviced interrupts wrap the counter
    pulse_sei();
    interrupt_request = 1'b1;
    for (int i = 0; i < 256; i++) begin
      wait_ack(n);
      if (n < 0) begin
        chki("wrap_ack_timeout", i, 256);
        break;
      end
      step();
      if (i == 254) chk8("count_255", irq_count, 8'd255);
      pulse_reti();
    end
    interrupt_request = 1'b0;
    chk8("count_wrap", irq_count, 8'h00);

    // Randomized commands and I-bit traffic, no interrupt requests
    do_reset(1);
    rst = 1'b0;
    begin
      int busy, wr_due, rd_due, rsp_due;
      logic m_i;
      logic [7:0] s_addr, s_wd, rsp_exp;
      busy = 0;
      wr_due = -1;
      rd_due = -1;
      rsp_due = -1;
      m_i = 1'b0;
      s_addr = 8'h00;
      s_wd = 8'h00;
      rsp_exp = 8'h00;
      for (int c = 0; c < 400; c++) begin
        logic ready_e;
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_write = 1'($urandom_range(0, 1));
        cmd_addr = 8'($urandom_range(0, 7));
        cmd_wdata = 8'($urandom);
        sei = ($urandom_range(0, 7) == 0);
        cli = ($urandom_range(0, 7) == 0);
        reti = ($urandom_range(0, 9) == 0);
        #1;
        ready_e = (busy == 0);
        chk1("rnd_ready", cmd_ready, ready_e);
        chk1("rnd_write", write, c == wr_due);
        chk1("rnd_read", read, c == rd_due);
        chk1("rnd_rsp_valid", rsp_valid, c == rsp_due);
        if (c == wr_due) begin
          chk8("rnd_wr_addr", addr, s_addr);
          chk8("rnd_wr_data", wdata, s_wd);
        end
        if (c == rd_due) chk8("rnd_rd_addr", addr, s_addr);
        if (c == rsp_due) chk8("rnd_rsp_data", rsp_rdata, rsp_exp);
        chk1("rnd_ibit", status_reg_interrupt_enable, m_i);
        chk1("rnd_no_ack", interrupt_executed, 1'b0);
        if (cmd_valid && ready_e) begin
          s_addr = cmd_addr;
          if (cmd_write) begin
            s_wd = cmd_wdata;
            ref_mem[cmd_addr] = cmd_wdata;
            wr_due = c + 1;
            busy = 1;
          end else begin
            rsp_exp = ref_mem[cmd_addr];
            rd_due = c + 1;
            rsp_due = c + 3;
            busy = 2;
          end
        end else if (busy > 0) begin
          busy--;
        end
        if (cli) m_i = 1'b0;
        else if (sei || reti) m_i = 1'b1;
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tc0_host.md
Name: tc0_host

Overview:
- Host-side (CPU-side) initiator for the timer0 register/interrupt interface.
- Turns a simple valid/ready command stream into single-cycle register write/read strobes toward the timer.
- Owns the global interrupt-enable (I) bit and services the timer's interrupt_request with a vectoring delay and an interrupt_executed acknowledge pulse.
- Used as the bus master in timer0 subsystem benches and as the CPU stand-in at top level.

Parameters:
IRQ_LATENCY, 4, cycles spent in VECTOR before acknowledge; legal range 1..15.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
cmd_valid  input  1  host command present
cmd_ready  output  1  command accepted when cmd_valid and cmd_ready both high
cmd_write  input  1  1 = register write, 0 = register read
cmd_addr  input  8  register address
cmd_wdata  input  8  write data
rsp_valid  output  1  one-cycle pulse: rsp_rdata valid
rsp_rdata  output  8  captured read data
sei  input  1  set I bit
cli  input  1  clear I bit
reti  input  1  return from ISR: clears in_isr, sets I bit
write  output  1  register write strobe to timer
read  output  1  register read strobe to timer
addr  output  8  register address to timer
wdata  output  8  write data to timer
rdata  input  8  read data from timer, valid the cycle after read
interrupt_request  input  1  level interrupt request from timer
status_reg_interrupt_enable  output  1  current I bit
interrupt_executed  output  1  one-cycle acknowledge to timer
in_isr  output  1  high from acknowledge until reti
irq_count  output  8  count of acknowledged interrupts, wraps 255 -> 0

Behaviour:
- Reset (sync, rst=1 at edge): state IDLE; every output 0, including I bit, rsp_rdata, irq_count and in_isr. Reset mid-transaction aborts it; no response is issued.
- States: IDLE, WR, RD, RDCAP, VECTOR, ACK.
- IDLE, checked in priority order:
  - interrupt_request=1 and I=1 and in_isr=0 -> VECTOR. I is cleared on this edge. The command is not accepted (cmd_ready=0 this cycle).
  - Otherwise cmd_ready=1. If cmd_valid, capture addr/wdata and go to WR (cmd_write=1) or RD (cmd_write=0).
- cmd_ready is high only in IDLE with no interrupt being taken; it is combinational from state, I, in_isr and interrupt_request.
- WR: write=1 for exactly one cycle with registered addr/wdata -> IDLE.
- RD: read=1 for exactly one cycle with addr -> RDCAP.
- RDCAP: sample rdata into rsp_rdata; rsp_valid=1 for one cycle -> IDLE.
- Strobe outputs (write, read) are 0 in every other state. addr/wdata hold their last value.
- Throughput: back-to-back commands give one write per 2 cycles and one read per 3 cycles.
- VECTOR: lasts exactly IRQ_LATENCY cycles (internal 4-bit down-counter) -> ACK.
- ACK: interrupt_executed=1 for one cycle; irq_count increments; in_isr set -> IDLE.
- Interrupt timing: if accepted at edge k, interrupt_executed is high in cycle k+IRQ_LATENCY+1.
- Interrupts are only taken from IDLE, so an in-flight bus transaction always completes first.
- I-bit update priority, highest first:
  - VECTOR entry clears I.
  - cli clears I.
  - sei or reti sets I.
  - So sei+cli in the same cycle leaves I=0, and reti+cli leaves I=0 with in_isr cleared.
- sei/cli/reti arriving during VECTOR or ACK update I per the priority above. reti never clears the in_isr set by the same cycle's ACK.
- No nesting: interrupt_request is ignored while in_isr=1 even if sei set I.
- A request that drops before acceptance is never taken. A request held high after ACK is taken again only after reti (or sei plus reti).

Test Plan:
- Reset then write: rst high 2 cycles; all outputs 0. Command write addr=0x44 data=0x05 -> write=1, addr=0x44, wdata=0x05 for exactly 1 cycle, 1 cycle after acceptance; cmd_ready low that cycle.
- Read: command read addr=0x46 with the bench returning rdata=0xA7 the cycle after read -> rsp_valid pulse with rsp_rdata=0xA7, 2 cycles after read. Back-to-back reads are accepted every 3 cycles.
- Interrupt with IRQ_LATENCY=4: sei, then interrupt_request=1 in IDLE -> status_reg_interrupt_enable falls the next cycle; interrupt_executed high exactly 5 cycles after acceptance for 1 cycle; irq_count=1; in_isr=1.
- Interrupt versus command in the same cycle: cmd_valid and interrupt_request both high with I=1 -> cmd_ready=0 and VECTOR taken; the command is accepted on the first IDLE cycle after ACK.
- Masking and priority:
  - cli with a pending request -> no acknowledge for 50 cycles.
  - sei+cli in the same cycle -> I=0.
  - Request held high after ACK -> no second ACK until reti, then ACK again and irq_count=2.
- Reset mid-operation: rst asserted during VECTOR -> no interrupt_executed, irq_count=0. Separately, 256 serviced interrupts make irq_count wrap to 0.
